// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: starts a CPU, records register writes and stores into a trace FIFO, flags halt/timeout.
// Define TRACE_MON_R0_FILTER_EN to suppress register-write records that target r0.
module cpu_trace_monitor #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int RST_CYCLES  = 1,
   parameter int MAX_CYCLES  = 560,
   parameter int HALT_REPEAT = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       run_i,
   input  logic [ADDR_W-1:0]          pc_i,
   input  logic                       regwrite_i,
   input  logic [4:0]                 rd_addr_i,
   input  logic [DATA_W-1:0]          wb_data_i,
   input  logic                       memwrite_i,
   input  logic [ADDR_W-1:0]          mem_addr_i,
   input  logic [DATA_W-1:0]          mem_data_i,
   output logic                       cpu_start_o,
   output logic                       trace_valid_o,
   output logic [2+ADDR_W+DATA_W-1:0] trace_data_o,
   input  logic                       trace_ready_i,
   output logic [31:0]                cycle_cnt_o,
   output logic                       done_o,
   output logic                       halt_o,
   output logic                       timeout_o,
   output logic                       overflow_o,
   output logic [15:0]                drop_cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int TW = 2 + ADDR_W + DATA_W;

   typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [31:0]       hold_cnt, same_cnt, same_nx, cyc_nx;
   logic [ADDR_W-1:0] pc_q;
   logic [TW-1:0]     mem [DEPTH];
   logic [TW-1:0]     rec;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       count;
   logic [16:0]       drop_sum;
   logic              running, reg_ev, want, coll, full, push, pop, ovf_ev, halt_ev, tmo_ev;

   assign running     = state == RUN;
   assign cpu_start_o = state == RUN || state == DONE;
   assign done_o      = state == DONE;

`ifdef TRACE_MON_R0_FILTER_EN
   assign reg_ev = regwrite_i && rd_addr_i != 5'd0;
`else
   assign reg_ev = regwrite_i;
`endif

   // same_cnt counts consecutive RUN cycles whose PC matches the previous cycle's PC
   assign same_nx = pc_i == pc_q ? same_cnt + 32'd1 : 32'd0;
   assign cyc_nx  = &cycle_cnt_o ? cycle_cnt_o : cycle_cnt_o + 32'd1;
   assign halt_ev = running && same_nx >= 32'(HALT_REPEAT);
   assign tmo_ev  = running && !halt_ev && cyc_nx >= 32'(MAX_CYCLES);

   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (run_i ? HOLD : IDLE)
               : state == HOLD ? (hold_cnt >= 32'(RST_CYCLES - 1) ? RUN : HOLD)
               : state == RUN  ? (halt_ev || tmo_ev ? DONE : RUN)
               : DONE;
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else       state <= state_nx;

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         hold_cnt    <= 32'd0;
         same_cnt    <= 32'd0;
         pc_q        <= '0;
         cycle_cnt_o <= 32'd0;
         halt_o      <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         hold_cnt <= state == HOLD ? hold_cnt + 32'd1 : 32'd0;
         same_cnt <= running ? same_nx : 32'd0;
         pc_q     <= pc_i;
         if (running) cycle_cnt_o <= cyc_nx;
         if (halt_ev) halt_o <= 1'b1;
         if (tmo_ev) timeout_o <= 1'b1;
      end

   // a store wins over a simultaneous register write; the register record is the one lost
   assign coll   = running && memwrite_i && reg_ev;
   assign want   = running && (memwrite_i || reg_ev);
   assign rec    = memwrite_i ? {2'b10, mem_addr_i, mem_data_i}
                              : {2'b01, ADDR_W'(rd_addr_i), wb_data_i};
   assign trace_valid_o = count != '0;
   assign trace_data_o  = trace_valid_o ? mem[rd_ptr] : '0;
   assign pop      = trace_valid_o && trace_ready_i;
   assign full     = count == (PW+1)'(DEPTH);
   assign push     = want && (!full || pop);
   assign ovf_ev   = want && full && !pop;
   assign drop_sum = {1'b0, drop_cnt_o} + 17'(coll) + 17'(ovf_ev);

   always_ff @(posedge clk_i)
      if (push) mem[wr_ptr] <= rec;

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
         drop_cnt_o <= 16'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count      <= count + (PW+1)'(push) - (PW+1)'(pop);
         drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (ovf_ev) overflow_o <= 1'b1;
      end
endmodule
